// File: rtl/tm_axis_pkg.sv
// Shared sizing helpers, default dimensions and types for the inference-result AXIS transmitter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: default dimensions, lane/beat helper functions, LPB/BEATS/REM/LANE_W for the defaults,
//           class_vec_t (one result vector) and tx_state_e (transmit FSM states).
package tm_axis_pkg;

   localparam int TDATA_WIDTH_DEF   = 64;
   localparam int CLASS_NUM_DEF     = 10;
   localparam int WEIGHT_LENGTH_DEF = 6;
   localparam int LANE_BYTES_DEF    = 1;
   localparam int BUF_DEPTH_DEF     = 2;

   // Lanes per bus beat.
   function automatic int calc_lpb(input int tdata_width, input int lane_bytes);
      return tdata_width / (8 * lane_bytes);
   endfunction

   // Beats needed to carry every class sum.
   function automatic int calc_beats(input int class_num, input int lpb);
      return (class_num + lpb - 1) / lpb;
   endfunction

   // Lanes occupied in the final sum beat.
   function automatic int calc_rem(input int class_num, input int lpb);
      return class_num - (calc_beats(class_num, lpb) - 1) * lpb;
   endfunction

   localparam int LANE_W = 8 * LANE_BYTES_DEF;
   localparam int LPB    = calc_lpb(TDATA_WIDTH_DEF, LANE_BYTES_DEF);
   localparam int BEATS  = calc_beats(CLASS_NUM_DEF, LPB);
   localparam int REM    = calc_rem(CLASS_NUM_DEF, LPB);

   typedef logic signed [CLASS_NUM_DEF-1:0][WEIGHT_LENGTH_DEF-1:0] class_vec_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      ARG  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/axis_result_fifo.sv
// Small synchronous FIFO holding whole result vectors (plus argmax index when enabled).
// Latency: a pushed entry is visible on head_dat the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop on empty is ignored.
// Ports: clk, rst_n (synchronous, active-low), push/push_dat, pop, head_dat, full, empty, count.
module axis_result_fifo #(
   parameter int WIDTH = 60,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full     = (count == DEPTH_CNT);
   assign empty    = (count == '0);
   assign rd_en    = pop && !empty;
   // When full, the write lands in the slot being popped this same edge.
   assign wr_en    = push && (!full || rd_en);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_dat;
      end
   end

endmodule

// File: rtl/axis_result_tx.sv
// AXI-Stream master sending one packet per captured class-sum vector (sign-extended lanes, tkeep on tail beat).
// Latency: finish in cycle N with idle FSM and empty buffer -> beat 0 valid in cycle N+1; packets back-to-back.
// Backpressure: tready=0 holds the current beat indefinitely; finish while the buffer is full is dropped and counted.
// Ports: m00_axis_aclk, m00_axis_aresetn (synchronous, active-low), finish, class_sums, result_ready,
//        m00_axis_tready/tvalid/tdata/tkeep/tstrb/tlast, overflow_cnt (saturating drop counter).
// Option: define TM_TX_ARGMAX_EN to append one argmax-index beat (byte0, tkeep=1) carrying tlast.
module axis_result_tx
   import tm_axis_pkg::*;
#(
   parameter int C_M00_AXIS_TDATA_WIDTH = TDATA_WIDTH_DEF,
   parameter int CLASS_NUM              = CLASS_NUM_DEF,
   parameter int WEIGHT_LENGTH          = WEIGHT_LENGTH_DEF,
   parameter int LANE_BYTES             = LANE_BYTES_DEF,
   parameter int BUF_DEPTH              = BUF_DEPTH_DEF
) (
   input  logic                                    m00_axis_aclk,
   input  logic                                    m00_axis_aresetn,
   input  logic                                    finish,
   input  logic [CLASS_NUM-1:0][WEIGHT_LENGTH-1:0] class_sums,
   output logic                                    result_ready,
   input  logic                                    m00_axis_tready,
   output logic                                    m00_axis_tvalid,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]       m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]     m00_axis_tkeep,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]     m00_axis_tstrb,
   output logic                                    m00_axis_tlast,
   output logic [15:0]                             overflow_cnt
);

   localparam int W      = C_M00_AXIS_TDATA_WIDTH;
   localparam int KW     = W / 8;
   localparam int LW     = 8 * LANE_BYTES;
   localparam int LANES  = calc_lpb(W, LANE_BYTES);
   localparam int NBEATS = calc_beats(CLASS_NUM, LANES);
   localparam int NREM   = calc_rem(CLASS_NUM, LANES);
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int SUM_W  = CLASS_NUM * WEIGHT_LENGTH;
   localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
`ifdef TM_TX_ARGMAX_EN
   localparam int ENT_W  = SUM_W + 8;
`else
   localparam int ENT_W  = SUM_W;
`endif
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
   localparam logic [KW-1:0]     KEEP_TAIL = {KW{1'b1}} >> (KW - NREM * LANE_BYTES);

   tx_state_e                               state;
   tx_state_e                               state_nxt;
   logic [BEAT_W-1:0]                       beat_cnt;
   logic [BEAT_W-1:0]                       beat_nxt;
   logic                                    push;
   logic                                    final_hs;
   logic                                    more;
   logic [ENT_W-1:0]                        push_dat;
   logic [ENT_W-1:0]                        head_dat;
   logic                                    fifo_full;
   logic                                    fifo_empty;
   logic [CNT_W-1:0]                        fifo_cnt;
   logic [CLASS_NUM-1:0][WEIGHT_LENGTH-1:0] head_sums;
   logic [NBEATS-1:0][W-1:0]                beat_dat;

   // ---------------------------------------------------------------- capture
`ifdef TM_TX_ARGMAX_EN
   logic signed [WEIGHT_LENGTH-1:0] best_val;
   logic [7:0]                      cap_idx;
   logic [7:0]                      head_idx;

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_val = $signed(class_sums[0]);
      cap_idx  = 8'd0;
      for (int i = 1; i < CLASS_NUM; i++) begin
         if ($signed(class_sums[i]) > best_val) begin
            best_val = $signed(class_sums[i]);
            cap_idx  = 8'(i);
         end
      end
   end

   assign push_dat = {cap_idx, class_sums};
   assign head_idx = head_dat[SUM_W +: 8];
   assign final_hs = (state == ARG) && m00_axis_tready;
`else
   assign push_dat = class_sums;
   assign final_hs = (state == SEND) && (beat_cnt == LAST_BEAT) && m00_axis_tready;
`endif

   // A full buffer still accepts when its head leaves on this same edge.
   assign push         = finish && (!fifo_full || final_hs);
   assign more         = (fifo_cnt > CNT_W'(1)) || push;
   assign result_ready = !fifo_full;

   always_ff @(posedge m00_axis_aclk) begin
      if (!m00_axis_aresetn) begin
         overflow_cnt <= '0;
      end else if (finish && !push && (overflow_cnt != 16'hFFFF)) begin
         overflow_cnt <= overflow_cnt + 16'd1;
      end
   end

   axis_result_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk      (m00_axis_aclk),
      .rst_n    (m00_axis_aresetn),
      .push     (push),
      .push_dat (push_dat),
      .pop      (final_hs),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   // ---------------------------------------------------------------- lane map
   assign head_sums = head_dat[SUM_W-1:0];

   for (genvar b = 0; b < NBEATS; b++) begin : g_beat
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         if (b * LANES + k < CLASS_NUM) begin : g_used
            assign beat_dat[b][k*LW +: LW] = LW'($signed(head_sums[b*LANES+k]));
         end else begin : g_pad
            assign beat_dat[b][k*LW +: LW] = '0;
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge m00_axis_aclk) begin
      if (!m00_axis_aresetn) begin
         state    <= IDLE;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   // Outputs are decoded from registered state and buffer head, so they only
   // move after a handshake edge and stay stable while tready is low.
   always_comb begin
      state_nxt       = state;
      beat_nxt        = beat_cnt;
      m00_axis_tvalid = 1'b0;
      m00_axis_tdata  = '0;
      m00_axis_tkeep  = '0;
      m00_axis_tlast  = 1'b0;
      case (state)
         IDLE: begin
            // Entering on the push itself gives single-cycle latency.
            if (!fifo_empty || push) begin
               state_nxt = SEND;
               beat_nxt  = '0;
            end
         end
         SEND: begin
            m00_axis_tvalid = 1'b1;
            m00_axis_tdata  = beat_dat[beat_cnt];
            if (beat_cnt == LAST_BEAT) begin
               m00_axis_tkeep = KEEP_TAIL;
`ifndef TM_TX_ARGMAX_EN
               m00_axis_tlast = 1'b1;
`endif
            end else begin
               m00_axis_tkeep = '1;
            end
            if (m00_axis_tready) begin
               if (beat_cnt == LAST_BEAT) begin
`ifdef TM_TX_ARGMAX_EN
                  state_nxt = ARG;
`else
                  state_nxt = more ? SEND : IDLE;
`endif
                  beat_nxt  = '0;
               end else begin
                  beat_nxt = beat_cnt + 1'b1;
               end
            end
         end
`ifdef TM_TX_ARGMAX_EN
         ARG: begin
            m00_axis_tvalid = 1'b1;
            m00_axis_tdata  = W'(head_idx);
            m00_axis_tkeep  = KW'(1);
            m00_axis_tlast  = 1'b1;
            if (m00_axis_tready) begin
               state_nxt = more ? SEND : IDLE;
               beat_nxt  = '0;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
            beat_nxt  = '0;
         end
      endcase
   end

   assign m00_axis_tstrb = m00_axis_tkeep;

endmodule
